// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128/192/256 key expansion, one 32-bit schedule word per clock, with a round-key read port.
// Latency: Nw-Nk cycles from the accepted start edge to the done pulse (40/46/52); reads are combinational.
// Backpressure: none; start is ignored while busy, and round keys read as zero until the schedule is complete.
module aes_key_schedule_ctrl #(
  parameter int x = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [0:127+64*x] key,
  output logic              busy,
  output logic              done,
  output logic              key_ready,
  input  logic [3:0]        rk_round,
  output logic              rk_valid,
  output logic [0:127]      round_key
);

  localparam int NK = 4 + 2*x;
  localparam int NR = 10 + 2*x;
  localparam int NW = 44 + 8*x;

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state, state_nxt;
  logic [5:0]  wi;          // index of the next word to be written
  logic [2:0]  kmod;        // wi mod Nk, tracked incrementally
  logic [7:0]  rcon;
  logic [31:0] w [NW];
  logic        load, wr_en, last;
  logic [31:0] w_prev, w_nk, sub_in, sub_out, new_word;
  logic [5:0]  rk_base;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign busy = (state == EXPAND);
  assign last = (wi == 6'(NW-1));

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, word counter, rcon and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wi        <= 6'd0;
      kmod      <= 3'd0;
      rcon      <= 8'h01;
      done      <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (load) begin
        wi        <= 6'(NK);
        kmod      <= 3'd0;
        rcon      <= 8'h01;
        key_ready <= 1'b0;
      end else if (wr_en) begin
        wi   <= wi + 6'd1;
        kmod <= (kmod == 3'(NK-1)) ? 3'd0 : kmod + 3'd1;
        if (kmod == 3'd0) rcon <= xtime(rcon);
        if (last) begin
          done      <= 1'b1;
          key_ready <= 1'b1;
        end
      end
    end
  end

  // Next schedule word from w[i-1] and w[i-Nk]; a single SubWord unit serves both substitution cases
  always_comb begin
    w_prev = w[wi - 6'd1];
    w_nk   = w[wi - 6'(NK)];
    sub_in = (kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    for (int k = 0; k < 4; k++) sub_out[8*k +: 8] = sbox(sub_in[8*k +: 8]);
    if (kmod == 3'd0)
      new_word = w_nk ^ sub_out ^ {rcon, 24'h000000};
    else if (x == 2 && kmod == 3'd4)
      new_word = w_nk ^ sub_out;
    else
      new_word = w_nk ^ w_prev;
  end

  // Word storage: key words on start, then one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < NK; j++) w[j] <= key[32*j +: 32];
    end else if (wr_en) begin
      w[wi] <= new_word;
    end
  end

  assign rk_valid = key_ready && (rk_round <= 4'(NR));
  assign rk_base  = {rk_round, 2'b00};

  // Round-key read; forced to zero whenever the index or schedule is not valid
  always_comb begin
    round_key = '0;
    if (rk_valid) begin
      for (int k = 0; k < 4; k++) round_key[32*k +: 32] = w[rk_base + 6'(k)];
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;

  logic         clk;
  logic         rst_n;
  logic [2:0]   start_v;
  logic [0:255] key_bus [3];
  logic [2:0]   busy_v, done_v, kr_v, rkv_v;
  logic [3:0]   rkr_v [3];
  logic [0:127] rkey_v [3];

  aes_key_schedule_ctrl #(.x(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key(key_bus[0][0:127]),
    .busy(busy_v[0]), .done(done_v[0]), .key_ready(kr_v[0]),
    .rk_round(rkr_v[0]), .rk_valid(rkv_v[0]), .round_key(rkey_v[0]));
  aes_key_schedule_ctrl #(.x(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key(key_bus[1][0:191]),
    .busy(busy_v[1]), .done(done_v[1]), .key_ready(kr_v[1]),
    .rk_round(rkr_v[1]), .rk_valid(rkv_v[1]), .round_key(rkey_v[1]));
  aes_key_schedule_ctrl #(.x(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key(key_bus[2][0:255]),
    .busy(busy_v[2]), .done(done_v[2]), .key_ready(kr_v[2]),
    .rk_round(rkr_v[2]), .rk_valid(rkv_v[2]), .round_key(rkey_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          dut;
    int          rnd;
    logic        vld;
    logic [127:0] val;
  } rd_t;

  rd_t  rd_q [$];
  int   dq0 [$];
  int   dq1 [$];
  int   dq2 [$];
  logic rd_req;
  logic [7:0]  sb [256];
  logic [31:0] mw [3][60];
  bit   kvalid [3];
  int   busy_cnt [3];
  bit   prev_done [3];

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void dq_push(input int d, input int v);
    case (d)
      0: dq0.push_back(v);
      1: dq1.push_back(v);
      default: dq2.push_back(v);
    endcase
  endfunction

  function automatic int dq_size(input int d);
    case (d)
      0: return dq0.size();
      1: return dq1.size();
      default: return dq2.size();
    endcase
  endfunction

  function automatic int dq_pop(input int d);
    case (d)
      0: return dq0.pop_front();
      1: return dq1.pop_front();
      default: return dq2.pop_front();
    endcase
  endfunction

  // Reference arithmetic: GF(2^8) product, S-box built by inverse search plus affine bit formula
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = 0;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int b = 0; b < 256; b++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[b] = s;
    end
  endtask

  function automatic logic [31:0] tb_sub(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int n);
    logic [7:0] rc;
    rc = 8'h01;
    for (int k = 1; k < n; k++) rc = tb_mul(rc, 8'h02);
    return rc;
  endfunction

  // FIPS-197 style expansion of the whole schedule for DUT d
  task automatic model(input int d, input logic [0:255] k);
    int nk, nw;
    logic [31:0] t;
    nk = 4 + 2*d;
    nw = 44 + 8*d;
    for (int i = 0; i < nk; i++) mw[d][i] = k[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[d][i-1];
      if (i % nk == 0)
        t = tb_sub({t[23:0], t[31:24]}) ^ {rcon_of(i/nk), 24'h0};
      else if (d == 2 && i % 8 == 4)
        t = tb_sub(t);
      mw[d][i] = mw[d][i-nk] ^ t;
    end
  endtask

  task automatic do_start(input int d, input logic [0:255] k, input bit expect_done);
    key_bus[d] = k;
    start_v[d] = 1'b1;
    if (expect_done) begin
      model(d, k);
      dq_push(d, 40 + 6*d);
      kvalid[d] = 0;
    end
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input bit chk_kr0);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (done_v[d]) found = 1;
      else begin
        if (chk_kr0 && busy_v[d]) chk($sformatf("key_ready_low_b2b d%0d", d), kr_v[d], 0);
        n++;
      end
    end
    if (!found) chk($sformatf("done_timeout d%0d", d), 0, 1);
    else chk($sformatf("key_ready_at_done d%0d", d), kr_v[d], 1);
    kvalid[d] = found;
  endtask

  task automatic rd(input int d, input int r, input bit use_c, input logic [127:0] cval);
    rd_t e;
    @(posedge clk);
    #1;
    rkr_v[d] = 4'(r);
    e.dut = d;
    e.rnd = r;
    if (use_c) begin
      e.vld = 1'b1;
      e.val = cval;
    end else begin
      e.vld = kvalid[d] && (r <= 10 + 2*d);
      e.val = e.vld ? {mw[d][4*r], mw[d][4*r+1], mw[d][4*r+2], mw[d][4*r+3]} : 128'h0;
    end
    rd_q.push_back(e);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic rd_all(input int d);
    for (int r = 0; r <= 11 + 2*d && r < 16; r++) rd(d, r, 0, 128'h0);
  endtask

  function automatic logic [0:255] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Monitor: pops expectations when the DUT signals done or a read is presented
  initial begin
    rd_t e;
    for (int d = 0; d < 3; d++) begin
      busy_cnt[d] = 0;
      prev_done[d] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int d = 0; d < 3; d++) begin
          busy_cnt[d] = 0;
          prev_done[d] = 0;
        end
      end else begin
        for (int d = 0; d < 3; d++) begin
          if (busy_v[d]) busy_cnt[d]++;
          if (done_v[d]) begin
            chk($sformatf("done_width d%0d", d), prev_done[d], 0);
            if (dq_size(d) == 0) chk($sformatf("unexpected_done d%0d", d), 1, 0);
            else chk($sformatf("busy_cycles d%0d", d), busy_cnt[d], dq_pop(d));
            busy_cnt[d] = 0;
          end
          prev_done[d] = done_v[d];
        end
        if (rd_req) begin
          if (rd_q.size() == 0) chk("read_without_expectation", 1, 0);
          else begin
            e = rd_q.pop_front();
            chk($sformatf("rk_valid d%0d r%0d", e.dut, e.rnd), rkv_v[e.dut], e.vld);
            chk($sformatf("round_key d%0d r%0d", e.dut, e.rnd), rkey_v[e.dut], e.val);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:255] ka, kb;
    rst_n   = 1'b0;
    start_v = 3'b000;
    rd_req  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      key_bus[d] = '0;
      rkr_v[d] = 4'd0;
      kvalid[d] = 0;
    end
    build_sbox();
    #23;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_busy d%0d", d), busy_v[d], 0);
      chk($sformatf("reset_done d%0d", d), done_v[d], 0);
      chk($sformatf("reset_key_ready d%0d", d), kr_v[d], 0);
    end
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) rd(d, 0, 0, 128'h0);

    // Known-answer vectors
    do_start(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1);
    wait_done(0, 0);
    rd(0, 1, 1, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(0, 10, 1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_all(0);
    do_start(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1);
    wait_done(0, 0);
    rd(0, 10, 1, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd(0, 0, 1, 128'h000102030405060708090a0b0c0d0e0f);
    do_start(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1);
    wait_done(1, 0);
    rd(1, 12, 1, 128'ha4970a331a78dc09c418c271e3a41d5d);
    rd_all(1);
    do_start(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1);
    wait_done(2, 0);
    rd(2, 14, 1, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd_all(2);

    // Random keys against the reference model
    for (int it = 0; it < 2; it++) begin
      for (int d = 0; d < 3; d++) begin
        do_start(d, rand_key(), 1);
        wait_done(d, 0);
        rd_all(d);
      end
    end

    // Start during EXPAND is ignored
    ka = rand_key();
    kb = rand_key();
    do_start(0, ka, 1);
    repeat (9) @(posedge clk);
    #1;
    do_start(0, kb, 0);
    wait_done(0, 0);
    rd_all(0);

    // Out-of-range round index
    rd(0, 11, 0, 128'h0);
    rd(0, 15, 0, 128'h0);
    rd(1, 13, 0, 128'h0);

    // Asynchronous reset in the middle of an expansion
    do_start(2, rand_key(), 0);
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("async_busy d%0d", d), busy_v[d], 0);
      chk($sformatf("async_key_ready d%0d", d), kr_v[d], 0);
      kvalid[d] = 0;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    rd(0, 1, 0, 128'h0);
    rd(2, 3, 0, 128'h0);
    @(posedge clk);
    #1;
    do_start(2, rand_key(), 1);
    wait_done(2, 0);
    rd_all(2);

    // Back-to-back: new start presented during the done cycle
    @(posedge clk);
    #1;
    do_start(0, rand_key(), 1);
    wait_done(0, 0);
    do_start(0, rand_key(), 1);
    wait_done(0, 1);
    rd_all(0);

    repeat (3) @(posedge clk);
    chk("pending_done_expectations", dq0.size() + dq1.size() + dq2.size(), 0);
    chk("pending_read_expectations", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
